// File: rtl/fetch_window_buffer_pkg.sv
// Shared types for the fetch-to-decode byte window.
// Window and count types match what the decoder consumes.
package FetchTypes;

  localparam int WIN_BYTES_DEF = 15;
  localparam int IN_BYTES_DEF  = 8;

  typedef logic [4:0]        byte_cnt_t;
  typedef logic [0:15*8-1]   win_t;

  // Occupancy clamped to the window size.
  function automatic byte_cnt_t clamp_cnt(
    input logic [5:0] cnt,
    input logic [5:0] lim
  );
    return (cnt > lim) ? lim[4:0] : cnt[4:0];
  endfunction

endpackage

// File: rtl/fetch_window_buffer_shift.sv
// Byte-granular left barrel shifter with zero fill.
// Byte 0 sits at bit 0 of the ascending-range vector.
module byte_shift_left #(
  parameter int N_BYTES = 32,
  parameter int SHIFT_W = 4
) (
  input  logic [0:N_BYTES*8-1] din,
  input  logic [SHIFT_W-1:0]   shamt,
  output logic [0:N_BYTES*8-1] dout
);

  logic [0:N_BYTES*8-1] stage [0:SHIFT_W];

  assign stage[0] = din;

  for (genvar s = 0; s < SHIFT_W; s++) begin : g_stage
    localparam int SH = 8 * (1 << s);
    if (SH >= N_BYTES * 8) begin : g_all
      assign stage[s+1] = shamt[s] ? '0 : stage[s];
    end else begin : g_part
      assign stage[s+1] = shamt[s] ? (stage[s] << SH) : stage[s];
    end
  end

  assign dout = stage[SHIFT_W];

endmodule

// File: rtl/fetch_window_buffer.sv
// Left-aligned byte staging buffer between fetch and decode.
// Retires decoder-consumed bytes, appends fetch chunks at the tail.
module fetch_window_buffer
  import FetchTypes::*;
#(
  parameter int BUF_BYTES = 32,
  parameter int IN_BYTES  = IN_BYTES_DEF,
  parameter int WIN_BYTES = WIN_BYTES_DEF,
  parameter int ADDR_W    = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [0:IN_BYTES*8-1]   in_data,
  output logic                    in_ready,
  output logic [0:WIN_BYTES*8-1]  win_bytes,
  output logic [4:0]              win_count,
  output logic                    win_valid,
  output logic [ADDR_W-1:0]       win_addr,
  input  logic                    consume_valid,
  input  logic [3:0]              consume_cnt,
  output logic                    consume_err,
  input  logic                    flush,
  input  logic [ADDR_W-1:0]       flush_addr
);

  localparam int BUF_W = BUF_BYTES * 8;
  localparam int IN_W  = IN_BYTES * 8;
  localparam int CNT_W = 6;

  localparam logic [CNT_W-1:0] RDY_MAX = CNT_W'(BUF_BYTES - IN_BYTES);
  localparam logic [CNT_W-1:0] WIN_N   = CNT_W'(WIN_BYTES);
  localparam logic [CNT_W-1:0] IN_N    = CNT_W'(IN_BYTES);

  logic [0:BUF_W-1]   buf_q, buf_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  win_addr_q, win_addr_d;
  logic               consume_err_q, consume_err_d;

  byte_cnt_t          avail;
  logic [CNT_W-1:0]   cons_k;
  logic [CNT_W-1:0]   shift_k;
  logic [CNT_W-1:0]   wr_off;
  logic               legal;
  logic               accept;
  logic [3:0]         shamt;
  logic [0:BUF_W-1]   shifted;
  logic [0:BUF_W-1]   chunk_ext;
  logic [0:BUF_W-1]   placed;

  assign avail     = clamp_cnt(cnt_q, WIN_N);
  assign in_ready  = (cnt_q <= RDY_MAX);
  assign win_count = avail;
  assign win_valid = ({1'b0, avail} == WIN_N);
  assign win_addr  = win_addr_q;
  assign consume_err = consume_err_q;

  always_comb begin
    win_bytes = '0;
    for (int i = 0; i < WIN_BYTES; i++) begin
      if (5'(i) < avail) win_bytes[i*8 +: 8] = buf_q[i*8 +: 8];
    end
  end

  assign cons_k  = {2'b00, consume_cnt};
  assign legal   = consume_valid & (|consume_cnt)
                 & (cons_k <= {1'b0, avail});
  assign shift_k = legal ? cons_k : '0;
  assign shamt   = legal ? consume_cnt : 4'd0;
  assign accept  = in_valid & in_ready;
  assign wr_off  = cnt_q - shift_k;

  byte_shift_left #(
    .N_BYTES (BUF_BYTES),
    .SHIFT_W (4)
  ) u_shift (
    .din   (buf_q),
    .shamt (shamt),
    .dout  (shifted)
  );

  // Mirror placement: chunk starts at byte 0, moved right to the tail.
  assign chunk_ext = {in_data, {(BUF_W - IN_W){1'b0}}};
  assign placed    = chunk_ext >> {wr_off, 3'b000};

  always_comb begin
    buf_d         = buf_q;
    cnt_d         = cnt_q;
    win_addr_d    = win_addr_q;
    consume_err_d = 1'b0;
    if (flush) begin
      buf_d      = '0;
      cnt_d      = '0;
      win_addr_d = flush_addr;
    end else begin
      buf_d         = shifted | (accept ? placed : '0);
      cnt_d         = wr_off + (accept ? IN_N : '0);
      win_addr_d    = win_addr_q + ADDR_W'(shift_k);
      consume_err_d = consume_valid & ~legal;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      buf_q         <= '0;
      cnt_q         <= '0;
      win_addr_q    <= '0;
      consume_err_q <= 1'b0;
    end else begin
      buf_q         <= buf_d;
      cnt_q         <= cnt_d;
      win_addr_q    <= win_addr_d;
      consume_err_q <= consume_err_d;
    end
  end

endmodule
